// File: rtl/step_level_tracker.sv
// Up/down level tracker: a steps up, b steps down, with saturate/wrap, edge/level stepping and
// post-step holdoff. Optional SLT_PEAK_EN adds a peak-level output.
module step_level_tracker #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_LEVEL = 11,
    parameter int unsigned WRAP      = 0,
    parameter int unsigned EDGE_MODE = 1,
    parameter int unsigned HOLDOFF   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             clr,
    output logic [WIDTH-1:0] level,
    output logic             at_min,
    output logic             at_max,
    output logic             step_up,
    output logic             step_dn,
    output logic             blocked,
    output logic             wrapped,
    output logic             busy
`ifdef SLT_PEAK_EN
    ,
    output logic [WIDTH-1:0] peak
`endif
);

    localparam logic [WIDTH-1:0] MaxLvl  = WIDTH'(MAX_LEVEL);
    localparam logic [7:0]       HoldCnt = 8'(HOLDOFF);

    typedef enum logic {StReady, StHold} state_e;

    state_e          state_q;
    logic [7:0]      cnt_q;
    logic            up_req, dn_req;
    logic            up_req_q, dn_req_q;
    logic            up_evt, dn_evt;
    logic            at_limit;
    logic [WIDTH-1:0] nxt_level;

    assign up_req = a & ~b;
    assign dn_req = b & ~a;
    assign up_evt = (EDGE_MODE != 0) ? (up_req & ~up_req_q) : up_req;
    assign dn_evt = (EDGE_MODE != 0) ? (dn_req & ~dn_req_q) : dn_req;

    assign at_min = (level == '0);
    assign at_max = (level == MaxLvl);
    assign busy   = (state_q == StHold);

    // Candidate level is computed without ever leaving 0..MAX_LEVEL.
    always_comb begin
        at_limit  = up_evt ? at_max : at_min;
        nxt_level = level;
        if (up_evt) begin
            nxt_level = at_max ? '0 : level + WIDTH'(1);
        end else if (dn_evt) begin
            nxt_level = at_min ? MaxLvl : level - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StReady;
            cnt_q    <= '0;
            level    <= '0;
            up_req_q <= 1'b1;
            dn_req_q <= 1'b1;
            step_up  <= 1'b0;
            step_dn  <= 1'b0;
            blocked  <= 1'b0;
            wrapped  <= 1'b0;
`ifdef SLT_PEAK_EN
            peak     <= '0;
`endif
        end else if (clr) begin
            state_q  <= StReady;
            cnt_q    <= '0;
            level    <= '0;
            up_req_q <= up_req;
            dn_req_q <= dn_req;
            step_up  <= 1'b0;
            step_dn  <= 1'b0;
            blocked  <= 1'b0;
            wrapped  <= 1'b0;
`ifdef SLT_PEAK_EN
            peak     <= '0;
`endif
        end else begin
            up_req_q <= up_req;
            dn_req_q <= dn_req;
            step_up  <= 1'b0;
            step_dn  <= 1'b0;
            blocked  <= 1'b0;
            wrapped  <= 1'b0;
            unique case (state_q)
                StReady: begin
                    if (up_evt || dn_evt) begin
                        if (at_limit && (WRAP == 0)) begin
                            blocked <= 1'b1;
                        end else begin
                            level   <= nxt_level;
                            step_up <= up_evt;
                            step_dn <= dn_evt;
                            wrapped <= at_limit;
`ifdef SLT_PEAK_EN
                            if (nxt_level > peak) peak <= nxt_level;
`endif
                            if (HOLDOFF != 0) begin
                                state_q <= StHold;
                                cnt_q   <= HoldCnt;
                            end
                        end
                    end
                end
                StHold: begin
                    // Events arriving here are dropped, not queued.
                    cnt_q <= cnt_q - 8'd1;
                    if (cnt_q <= 8'd1) state_q <= StReady;
                end
                default: state_q <= StReady;
            endcase
        end
    end

endmodule

// File: tb/tb_step_level_tracker.sv
// Randomized bench: four tracker configurations share stimulus and are compared every cycle
// against a cycle-indexed behavioural model.
module tb_step_level_tracker;

    localparam int N = 4;

    function automatic int cfg_max(input int i);
        return (i == 3) ? 5 : 11;
    endfunction
    function automatic int cfg_wrap(input int i);
        return (i == 1 || i == 3) ? 1 : 0;
    endfunction
    function automatic int cfg_edge(input int i);
        return (i < 2) ? 1 : 0;
    endfunction
    function automatic int cfg_hold(input int i);
        case (i)
            0: return 3;
            1: return 2;
            2: return 0;
            default: return 1;
        endcase
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b1, a = 1'b0, b = 1'b0, clr = 1'b0;
    logic [3:0] lvl [N];
    logic [3:0] pk  [N];
    logic [N-1:0] at_min_w, at_max_w, up_w, dn_w, blk_w, wrp_w, busy_w;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        step_level_tracker #(
            .WIDTH(4),
            .MAX_LEVEL(cfg_max(g)),
            .WRAP(cfg_wrap(g)),
            .EDGE_MODE(cfg_edge(g)),
            .HOLDOFF(cfg_hold(g))
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .a(a),
            .b(b),
            .clr(clr),
            .level(lvl[g]),
            .at_min(at_min_w[g]),
            .at_max(at_max_w[g]),
            .step_up(up_w[g]),
            .step_dn(dn_w[g]),
            .blocked(blk_w[g]),
            .wrapped(wrp_w[g]),
            .busy(busy_w[g])
`ifdef SLT_PEAK_EN
            ,
            .peak(pk[g])
`endif
        );
`ifndef SLT_PEAK_EN
        assign pk[g] = '0;
`endif
    end

    // Model state: level as plain integer, holdoff as "first cycle index that may accept".
    typedef struct {
        int level;
        int peak;
        bit pu;
        bit pd;
        int free_from;
        bit s_up;
        bit s_dn;
        bit blk;
        bit wrp;
    } mdl_t;

    mdl_t m [N];
    int   t = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, t, got, exp);
        end
    endtask

    function automatic mdl_t mstep(input int i, input mdl_t cur, input bit r, input bit cl,
                                   input bit aa, input bit bb, input int now);
        mdl_t nx = cur;
        bit ur = aa && !bb;
        bit dr = bb && !aa;
        bit ue, de, stepped;
        int target;
        nx.s_up = 0; nx.s_dn = 0; nx.blk = 0; nx.wrp = 0;
        if (r || cl) begin
            nx.level = 0; nx.peak = 0; nx.free_from = 0;
            nx.pu = r ? 1'b1 : ur;
            nx.pd = r ? 1'b1 : dr;
            return nx;
        end
        ue = (cfg_edge(i) != 0) ? (ur && !cur.pu) : ur;
        de = (cfg_edge(i) != 0) ? (dr && !cur.pd) : dr;
        nx.pu = ur;
        nx.pd = dr;
        if ((ue || de) && now >= cur.free_from) begin
            target  = ue ? cur.level + 1 : cur.level - 1;
            stepped = 1;
            if (target > cfg_max(i) || target < 0) begin
                if (cfg_wrap(i) == 0) begin
                    nx.blk  = 1;
                    stepped = 0;
                end else begin
                    nx.level = (target < 0) ? cfg_max(i) : 0;
                    nx.wrp   = 1;
                end
            end else begin
                nx.level = target;
            end
            if (stepped) begin
                nx.s_up = ue;
                nx.s_dn = de;
                nx.free_from = now + cfg_hold(i) + 1;
                if (nx.level > nx.peak) nx.peak = nx.level;
            end
        end
        return nx;
    endfunction

    task automatic compare_all();
        for (int i = 0; i < N; i++) begin
            check_eq($sformatf("d%0d level", i), 32'(lvl[i]), m[i].level);
            check_eq($sformatf("d%0d at_min", i), 32'(at_min_w[i]), 32'(m[i].level == 0));
            check_eq($sformatf("d%0d at_max", i), 32'(at_max_w[i]),
                     32'(m[i].level == cfg_max(i)));
            check_eq($sformatf("d%0d step_up", i), 32'(up_w[i]), 32'(m[i].s_up));
            check_eq($sformatf("d%0d step_dn", i), 32'(dn_w[i]), 32'(m[i].s_dn));
            check_eq($sformatf("d%0d blocked", i), 32'(blk_w[i]), 32'(m[i].blk));
            check_eq($sformatf("d%0d wrapped", i), 32'(wrp_w[i]), 32'(m[i].wrp));
            check_eq($sformatf("d%0d busy", i), 32'(busy_w[i]), 32'(t < m[i].free_from - 1));
`ifdef SLT_PEAK_EN
            check_eq($sformatf("d%0d peak", i), 32'(pk[i]), m[i].peak);
`endif
        end
    endtask

    task automatic cycle(input bit r, input bit cl, input bit aa, input bit bb);
        rst = r; clr = cl; a = aa; b = bb;
        @(posedge clk);
        for (int i = 0; i < N; i++) m[i] = mstep(i, m[i], r, cl, aa, bb, t);
        #1;
        compare_all();
        t++;
    endtask

    int  bias;
    bit  ra, rb, rc, rr;

    initial begin
        // Reset with a held high, then release and keep it high before re-asserting.
        cycle(1, 0, 1, 0);
        cycle(1, 0, 1, 0);
        for (int k = 0; k < 3; k++) cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        // Separated up pulses run every config into its upper limit.
        for (int k = 0; k < 14; k++) begin
            cycle(0, 0, 1, 0);
            for (int j = 0; j < 4; j++) cycle(0, 0, 0, 0);
        end
        // Both requests held: never an event.
        for (int k = 0; k < 5; k++) cycle(0, 0, 1, 1);
        cycle(0, 0, 0, 0);
        // Down steps, then clear in the middle of a holdoff.
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        cycle(0, 1, 0, 1);
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        // Down pulses from zero exercise the lower limit and down-wrap.
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, 1);
            for (int j = 0; j < 4; j++) cycle(0, 0, 0, 0);
        end
        // Randomized phases biased towards up, down or unbiased traffic.
        for (int p = 0; p < 40; p++) begin
            bias = int'($urandom_range(2, 0));
            for (int k = 0; k < 80; k++) begin
                rr = ($urandom_range(399, 0) == 0);
                rc = ($urandom_range(99, 0) == 0);
                ra = 1'($urandom_range(1, 0));
                rb = 1'($urandom_range(1, 0));
                if (bias == 1) rb = ($urandom_range(9, 0) == 0);
                if (bias == 2) ra = ($urandom_range(9, 0) == 0);
                cycle(rr, rc, ra, rb);
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
